// File: rtl/lsu_bus_bridge.sv
// rtl/lsu_bus_bridge.sv - load/store unit bridging the single-cycle datapath to a valid/ready word bus
// Holds the core with Stall while an access is in flight; steers byte lanes and extends loads.

module lsu_bus_bridge #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AccessFault,
   output logic        BusFault,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [31:0] rdata_q;

   logic        req, size_ok, align_ok, legal;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_v;

   always_comb begin
      req = MemRead | MemWrite;
      case (Funct3)
         3'b000, 3'b001, 3'b010: size_ok = 1'b1;
         3'b100, 3'b101:         size_ok = ~MemWrite;
         default:                size_ok = 1'b0;
      endcase
      case (Funct3[1:0])
         2'b01:   align_ok = ~ALUResult[0];
         2'b10:   align_ok = (ALUResult[1:0] == 2'b00);
         default: align_ok = 1'b1;
      endcase
      legal = size_ok & align_ok & ~(MemRead & MemWrite);

      case (Funct3[1:0])
         2'b00: begin
            be_n    = 4'b0001 << ALUResult[1:0];
            wdata_n = {4{WriteData[7:0]}};
         end
         2'b01: begin
            be_n    = ALUResult[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{WriteData[15:0]}};
         end
         default: begin
            be_n    = 4'b1111;
            wdata_n = WriteData;
         end
      endcase
   end

   // Lane extraction uses the offset captured at issue, not the live ALUResult.
   always_comb begin
      byte_v = bus_rdata[{off_q, 3'b000} +: 8];
      half_v = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (f3_q)
         3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
         3'b001:  load_v = {{16{half_v[15]}}, half_v};
         3'b100:  load_v = {24'd0, byte_v};
         3'b101:  load_v = {16'd0, half_v};
         default: load_v = bus_rdata;
      endcase
   end

   assign AccessFault = (state == IDLE) && req && !legal;
   assign Stall       = ((state == IDLE) && req && legal) || (state == REQ) || (state == WAIT);
   assign ReadData    = AccessFault ? 32'd0 : rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 16'd0;
         f3_q      <= 3'd0;
         off_q     <= 2'd0;
         rdata_q   <= 32'd0;
         BusFault  <= 1'b0;
         bus_valid <= 1'b0;
         bus_addr  <= 32'd0;
         bus_we    <= 1'b0;
         bus_be    <= 4'd0;
         bus_wdata <= 32'd0;
      end else begin
         BusFault <= 1'b0;
         case (state)
            IDLE: begin
               if (req && legal) begin
                  bus_addr  <= {ALUResult[31:2], 2'b00};
                  bus_be    <= be_n;
                  bus_wdata <= wdata_n;
                  bus_we    <= MemWrite;
                  f3_q      <= Funct3;
                  off_q     <= ALUResult[1:0];
                  bus_valid <= 1'b1;
                  cnt       <= 16'd0;
                  state     <= REQ;
               end
            end
            REQ, WAIT: begin
               cnt <= cnt + 16'd1;
               // Timeout wins even if the bus answers in the same cycle.
               if (cnt == TLIM) begin
                  BusFault  <= 1'b1;
                  bus_valid <= 1'b0;
                  rdata_q   <= 32'd0;
                  state     <= DONE;
               end else if (state == REQ) begin
                  if (bus_ready) begin
                     bus_valid <= 1'b0;
                     state     <= bus_we ? DONE : WAIT;
                  end
               end else if (bus_rsp_valid) begin
                  rdata_q <= load_v;
                  state   <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// tb/tb_lsu_bus_bridge.sv - randomized self-checking bench for lsu_bus_bridge
// Expected bus fields, latency and load results come from a size/offset arithmetic model.

module tb_lsu_bus_bridge;

   localparam int T = 4;

   logic        clk;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] ALUResult, WriteData;
   logic [31:0] ReadData;
   logic        Stall, AccessFault, BusFault;
   logic        bus_valid, bus_ready, bus_we, bus_rsp_valid;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int          ncmp = 0;
   int          nerr = 0;
   logic [31:0] model_rd = 32'd0;

   lsu_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
      .ALUResult(ALUResult), .WriteData(WriteData),
      .ReadData(ReadData), .Stall(Stall), .AccessFault(AccessFault), .BusFault(BusFault),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int size_bytes(input logic [2:0] f3);
      return 1 << int'(f3[1:0]);
   endfunction

   function automatic bit is_legal(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] a);
      if (mr && mw) return 0;
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 0;
      if (f3 >= 3'd4 && mw) return 0;
      return (int'(a[1:0]) % size_bytes(f3)) == 0;
   endfunction

   function automatic logic [31:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] m;
      m = (32'd1 << size_bytes(f3)) - 32'd1;
      return m << a[1:0];
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (size_bytes(f3))
         1:       return (wd & 32'h0000_00FF) * 32'h0101_0101;
         2:       return (wd & 32'h0000_FFFF) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v, mask;
      int n;
      n = size_bytes(f3);
      v = rd >> (8 * int'(a[1:0]));
      if (n == 4) return v;
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (f3 < 3'd4 && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic access(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int r, input int p, input logic [31:0] rd);
      int k, e;
      bit tmo;
      @(negedge clk);
      MemRead = mr; MemWrite = mw; Funct3 = f3; ALUResult = a; WriteData = wd;
      bus_ready = 1'b0; bus_rsp_valid = 1'b0;
      #1;
      check("busfault_idle", 32'(BusFault), 32'd0);
      if (!mr && !mw) begin
         check("idle_stall", 32'(Stall), 32'd0);
         check("idle_afault", 32'(AccessFault), 32'd0);
         return;
      end
      if (!is_legal(mr, mw, f3, a)) begin
         check("afault", 32'(AccessFault), 32'd1);
         check("afault_stall", 32'(Stall), 32'd0);
         check("afault_valid", 32'(bus_valid), 32'd0);
         check("afault_rd", ReadData, 32'd0);
         @(negedge clk);
         MemRead = 1'b0; MemWrite = 1'b0;
         #1;
         check("afault_no_req", 32'(bus_valid), 32'd0);
         check("afault_rd_after", ReadData, model_rd);
         return;
      end
      check("stall_issue", 32'(Stall), 32'd1);
      check("afault_none", 32'(AccessFault), 32'd0);
      k   = mw ? r + 1 : r + 2 + p;
      tmo = (k >= T);
      e   = tmo ? T : k;
      for (int i = 1; i <= e; i++) begin
         @(negedge clk);
         bus_ready     = (i == r + 1);
         bus_rsp_valid = (!mw && i == r + 2 + p);
         bus_rdata     = bus_rsp_valid ? rd : $urandom;
         #1;
         check("stall_busy", 32'(Stall), 32'd1);
         check("valid_phase", 32'(bus_valid), 32'(i <= r + 1));
         if (i == 1) begin
            check("bus_addr", bus_addr, {a[31:2], 2'b00});
            check("bus_be", 32'(bus_be), exp_be(f3, a));
            check("bus_we", 32'(bus_we), 32'(mw));
            if (mw) check("bus_wdata", bus_wdata, exp_wdata(f3, wd));
         end
      end
      @(negedge clk);
      bus_ready = 1'b0; bus_rsp_valid = 1'b0;
      #1;
      if (tmo) model_rd = 32'd0;
      else if (mr) model_rd = exp_load(f3, a, rd);
      check("done_stall", 32'(Stall), 32'd0);
      check("done_valid", 32'(bus_valid), 32'd0);
      check("busfault", 32'(BusFault), 32'(tmo));
      check("readdata", ReadData, model_rd);
   endtask

   initial begin
      reset = 1'b0;
      MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd0; ALUResult = 32'd0; WriteData = 32'd0;
      bus_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_stall", 32'(Stall), 32'd0);
      check("rst_valid", 32'(bus_valid), 32'd0);
      check("rst_be", 32'(bus_be), 32'd0);
      check("rst_rd", ReadData, 32'd0);
      reset = 1'b1;

      access(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 32'd0);
      access(1'b0, 1'b1, 3'd0, 32'h103, 32'h000000A5, 0, 0, 32'd0);
      access(1'b1, 1'b0, 3'd0, 32'h102, 32'd0, 0, 0, 32'h0080FF00);
      access(1'b1, 1'b0, 3'd4, 32'h102, 32'd0, 1, 0, 32'h0080FF00);
      access(1'b1, 1'b0, 3'd1, 32'h102, 32'd0, 0, 1, 32'h0080FF00);
      access(1'b1, 1'b0, 3'd2, 32'h101, 32'd0, 0, 0, 32'd0);
      access(1'b1, 1'b1, 3'd2, 32'h100, 32'd0, 0, 0, 32'd0);
      access(1'b1, 1'b0, 3'd2, 32'h200, 32'd0, 1000, 0, 32'd0);

      // Reset asserted while the load sits in WAIT.
      @(negedge clk);
      MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'd2; ALUResult = 32'h300;
      @(negedge clk);
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      #1;
      check("wait_stall", 32'(Stall), 32'd1);
      reset = 1'b0; MemRead = 1'b0;
      #1;
      check("midrst_stall", 32'(Stall), 32'd0);
      check("midrst_valid", 32'(bus_valid), 32'd0);
      check("midrst_addr", bus_addr, 32'd0);
      check("midrst_wdata", bus_wdata, 32'd0);
      check("midrst_rd", ReadData, 32'd0);
      model_rd = 32'd0;
      @(negedge clk);
      reset = 1'b1;
      access(1'b1, 1'b0, 3'd2, 32'h304, 32'd0, 0, 0, 32'h12345678);

      for (int n = 0; n < 300; n++) begin
         int sel, r, p;
         logic mr, mw;
         sel = $urandom_range(0, 19);
         mr  = (sel < 9) || (sel == 18);
         mw  = (sel >= 9 && sel < 18) || (sel == 18);
         r   = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 2);
         p   = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 1);
         access(mr, mw, 3'($urandom_range(0, 7)), $urandom, $urandom, r, p, $urandom);
      end

      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
Load/store unit sitting directly downstream of the single-cycle datapath: it consumes the datapath's ALUResult (address), WriteData and memory-control signals and produces ReadData. It converts each load/store into a valid/ready transaction on a 32-bit word-addressed memory bus, and holds the core with Stall until the access completes. It also handles byte/halfword lane steering, sign/zero extension, misalignment, illegal size and bus-timeout faults.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before the access is aborted with BusFault (1..65535)

Ports:
clk  in  1  core clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
MemRead  in  1  load request from control unit
MemWrite  in  1  store request from control unit
Funct3  in  3  Instr[14:12]; access size and signedness
ALUResult  in  32  byte address
WriteData  in  32  store data (rs2)
ReadData  out  32  extended load result to the result mux
Stall  out  1  1 = core must hold PC and suppress RegWrite
AccessFault  out  1  one-cycle pulse: misaligned, illegal Funct3, or MemRead&MemWrite
BusFault  out  1  one-cycle pulse: timeout abort
bus_valid  out  1  request valid
bus_ready  in  1  request accepted
bus_addr  out  32  {ALUResult[31:2],2'b00}
bus_we  out  1  1 = write
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_rsp_valid  in  1  read data valid (reads only)
bus_rdata  in  32  read word

Behaviour:
- Reset (reset=0, async): state IDLE, timeout counter 0, ReadData 0, bus_valid 0, bus_we 0, bus_be 0, bus_addr 0, bus_wdata 0, Stall 0, faults 0. Reset mid-transaction abandons it; bus must tolerate a dropped request.
- Sizes: Funct3 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU. 100/101 with MemWrite, and 011/110/111 are illegal.
- Alignment: halfword needs ALUResult[0]=0; word needs ALUResult[1:0]=0.
- FSM states IDLE, REQ, WAIT, DONE.
- IDLE: if (MemRead|MemWrite) and access legal: Stall=1 combinationally; register address, be, wdata, we, Funct3, offset ALUResult[1:0]; go REQ. If illegal (misaligned, illegal size, or both MemRead and MemWrite): AccessFault=1 combinationally for this cycle, Stall=0, no bus request, ReadData forced 0 that cycle, stay IDLE. Otherwise Stall=0.
- REQ: bus_valid=1, bus fields stable from registers, Stall=1. On bus_ready: store -> DONE; load -> WAIT.
- WAIT: Stall=1. On bus_rsp_valid: extract and extend from bus_rdata, register into ReadData, go DONE. A bus_rsp_valid in any other state is ignored.
- DONE: Stall=0, ReadData holds the result; the core commits the instruction this cycle; go IDLE unconditionally (no re-trigger on the same instruction).
- Timeout: counter clears on entering REQ and increments each cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES: BusFault=1 for one cycle, bus_valid drops, ReadData=0, go DONE.
- Store lanes: SB be=4'b0001<<off, wdata={4{WriteData[7:0]}}. SH be=off[1]?1100:0011, wdata={2{WriteData[15:0]}}. SW be=1111, wdata=WriteData.
- Load extract: byte=rdata[8*off+:8]; half=rdata[16*off[1]+:16]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Latency: a store is at least 2 stall cycles (IDLE, REQ) plus 1 DONE cycle. A load with ready and rsp_valid each arriving 1 cycle after valid occupies IDLE→REQ→WAIT→DONE (3 stall cycles).

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, bus_ready=1 in first REQ cycle -> bus_addr 0x100, be 1111, wdata 0xDEADBEEF, we 1; Stall high 2 cycles, DONE 1 cycle.
- SB addr 0x103, data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5.
- LB addr 0x102, bus_rdata 0x0080FF00 -> ReadData 0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x102 -> 0x00000080.
- LW addr 0x101 -> AccessFault pulse, bus_valid stays 0, Stall 0, ReadData 0. MemRead&MemWrite together -> AccessFault.
- TIMEOUT_CYCLES=4, LW with bus_ready never asserted -> BusFault after 4 cycles in REQ, ReadData 0, returns IDLE via DONE.
- Assert reset mid-WAIT -> immediate IDLE, all outputs 0; the next LW completes normally.
